// File: rtl/fetch_pc_unit.sv
// ----------------------------------------------------------------------------
// fetch_pc_unit
//   Program counter plus IF/ID pipeline latch for the 5-stage core. Holds the
//   PC, drives the instruction-memory address/enable and captures the fetched
//   word, its PC and its sequential successor into the IF/ID latch.
//   After reset the unit waits BOOT_CYCLES cycles before the first fetch.
//   Per-edge priority while running: redirect > stall > sequential.
//
// Optional feature (macro FETCH_PERF_CNT_EN):
//   defined     -> fetch_count / bubble_count are live 32-bit wrapping counters
//   not defined -> both outputs are tied to 0 and no counter flops exist
//
// Ports:
//   CLOCK_50       in   system clock, rising edge
//   reset          in   asynchronous active-high reset
//   stall          in   hold PC and IF/ID latch
//   redirect       in   taken branch/jump, loads redirect_addr
//   redirect_addr  in   redirect target
//   flush          in   invalidate IF/ID latch contents
//   imem_data      in   instruction at imem_addr (combinational read)
//   imem_addr      out  current PC
//   imem_en        out  instruction-memory read enable
//   pc_wr_en       out  PC updates at this edge
//   fe_latch_wr    out  IF/ID latch loads at this edge
//   id_instr       out  latched instruction
//   id_pc          out  PC of latched instruction
//   id_next_pc     out  id_pc + PC_STEP (wrapping)
//   id_valid       out  latch holds a real instruction
//   fetch_count    out  fetched-instruction counter
//   bubble_count   out  inserted-bubble counter
// ----------------------------------------------------------------------------
module fetch_pc_unit #(
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned INSTR_W     = 16,
    parameter int unsigned RESET_VEC   = 16,
    parameter int unsigned PC_STEP     = 1,
    parameter int unsigned BOOT_CYCLES = 1
) (
    input  logic               CLOCK_50,
    input  logic               reset,
    input  logic               stall,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_addr,
    input  logic               flush,
    input  logic [INSTR_W-1:0] imem_data,
    output logic [ADDR_W-1:0]  imem_addr,
    output logic               imem_en,
    output logic               pc_wr_en,
    output logic               fe_latch_wr,
    output logic [INSTR_W-1:0] id_instr,
    output logic [ADDR_W-1:0]  id_pc,
    output logic [ADDR_W-1:0]  id_next_pc,
    output logic               id_valid,
    output logic [31:0]        fetch_count,
    output logic [31:0]        bubble_count
);

    localparam int unsigned BOOT_W = (BOOT_CYCLES < 2) ? 1 : $clog2(BOOT_CYCLES + 1);

    localparam logic [ADDR_W-1:0] LP_RESET_PC  = ADDR_W'(RESET_VEC);
    localparam logic [ADDR_W-1:0] LP_STEP      = ADDR_W'(PC_STEP);
    localparam logic [BOOT_W-1:0] LP_BOOT_LAST = BOOT_W'(BOOT_CYCLES - 1);

    typedef enum logic [0:0] {
        StBoot,
        StRun
    } state_t;

    state_t              r_state;
    logic [BOOT_W-1:0]   r_boot_cnt;
    logic [ADDR_W-1:0]   r_pc;
    logic [INSTR_W-1:0]  r_id_instr;
    logic [ADDR_W-1:0]   r_id_pc;
    logic [ADDR_W-1:0]   r_id_next_pc;
    logic                r_id_valid;

    logic                w_run;
    logic                w_advance;
    logic [ADDR_W-1:0]   w_pc_inc;

    assign w_run     = (r_state == StRun);
    // Redirect overrides stall, so the PC moves whenever either redirect or no stall.
    assign w_advance = w_run & (redirect | ~stall);
    // Natural truncation to ADDR_W bits gives the modulo-2^ADDR_W wrap.
    assign w_pc_inc  = r_pc + LP_STEP;

    assign imem_addr   = r_pc;
    assign imem_en     = w_run;
    assign pc_wr_en    = w_advance;
    assign fe_latch_wr = w_advance;
    assign id_instr    = r_id_instr;
    assign id_pc       = r_id_pc;
    assign id_next_pc  = r_id_next_pc;
    assign id_valid    = r_id_valid;

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_state      <= StBoot;
            r_boot_cnt   <= '0;
            r_pc         <= LP_RESET_PC;
            r_id_instr   <= '0;
            r_id_pc      <= '0;
            r_id_next_pc <= '0;
            r_id_valid   <= 1'b0;
        end else begin
            unique case (r_state)
                StBoot: begin
                    r_boot_cnt <= r_boot_cnt + BOOT_W'(1);
                    if (r_boot_cnt == LP_BOOT_LAST) begin
                        r_state <= StRun;
                    end
                end
                StRun: begin
                    if (redirect) begin
                        // Bubble: latch fields keep their old contents, only valid drops.
                        r_pc       <= redirect_addr;
                        r_id_valid <= 1'b0;
                    end else if (stall) begin
                        if (flush) begin
                            r_id_valid <= 1'b0;
                        end
                    end else begin
                        r_pc         <= w_pc_inc;
                        r_id_instr   <= imem_data;
                        r_id_pc      <= r_pc;
                        r_id_next_pc <= w_pc_inc;
                        r_id_valid   <= ~flush;
                    end
                end
                default: r_state <= StBoot;
            endcase
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic        w_fetch_evt;
    logic        w_bubble_evt;
    logic [31:0] r_fetch_count;
    logic [31:0] r_bubble_count;

    assign w_fetch_evt  = w_run & ~redirect & ~stall & ~flush;
    assign w_bubble_evt = w_run & (redirect | flush);

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_fetch_count  <= '0;
            r_bubble_count <= '0;
        end else begin
            if (w_fetch_evt) begin
                r_fetch_count <= r_fetch_count + 32'd1;
            end
            if (w_bubble_evt) begin
                r_bubble_count <= r_bubble_count + 32'd1;
            end
        end
    end

    assign fetch_count  = r_fetch_count;
    assign bubble_count = r_bubble_count;
`else
    assign fetch_count  = 32'd0;
    assign bubble_count = 32'd0;
`endif

endmodule

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
- Parametrised program-counter and fetch/decode pipeline latch for the 5-stage processor.
- Supersedes the fixed PC-start constant driver: reset vector, address/instruction widths and PC step are parameters.
- Adds boot delay, stall, branch redirect, flush/bubble insertion and PC wrap handling.
- Sits between instruction memory and the ID stage; drives instruction-memory address/enable and the IF/ID latch.

Parameters:
- ADDR_W, 16, PC/instruction-address width.
- INSTR_W, 16, instruction word width.
- RESET_VEC, 16, PC value loaded on reset.
- PC_STEP, 1, sequential PC increment, in address units.
- BOOT_CYCLES, 1, cycles after reset release before the first fetch (>=1).

Ports:
- CLOCK_50  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- stall  in  1  hold the PC and the IF/ID latch (hazard from ID).
- redirect  in  1  taken branch/jump; load redirect_addr.
- redirect_addr  in  ADDR_W  redirect target.
- flush  in  1  invalidate the IF/ID latch contents.
- imem_data  in  INSTR_W  instruction read combinationally at imem_addr.
- imem_addr  out  ADDR_W  current PC.
- imem_en  out  1  instruction-memory read enable.
- pc_wr_en  out  1  PC updates at this edge.
- fe_latch_wr  out  1  IF/ID latch loads at this edge.
- id_instr  out  INSTR_W  latched instruction.
- id_pc  out  ADDR_W  PC of the latched instruction.
- id_next_pc  out  ADDR_W  id_pc + PC_STEP, modulo 2^ADDR_W.
- id_valid  out  1  latch holds a real instruction.
- fetch_count  out  32  fetched-instruction counter (see Optional Feature).
- bubble_count  out  32  inserted-bubble counter (see Optional Feature).

Behaviour:
- States: BOOT, RUN.
- Reset (asynchronous): state=BOOT, boot counter=0, PC=RESET_VEC, id_instr=0, id_pc=0, id_next_pc=0, id_valid=0, counters=0.
- BOOT: imem_en=0, pc_wr_en=0, fe_latch_wr=0; inputs ignored.
  - Counter increments each cycle; after BOOT_CYCLES cycles, go to RUN.
  - First fetch is therefore at cycle BOOT_CYCLES after reset release.
- RUN: imem_en=1. Priority per edge: redirect > stall > sequential.
  - redirect=1: PC<=redirect_addr; id_valid<=0 (bubble). Applies even when stall=1. fe_latch_wr=1, pc_wr_en=1.
  - stall=1, redirect=0: PC and all id_* outputs hold. pc_wr_en=0, fe_latch_wr=0. If flush=1, id_valid<=0 and other fields hold.
  - Otherwise: PC<=PC+PC_STEP, wrapping modulo 2^ADDR_W. id_instr<=imem_data, id_pc<=PC, id_next_pc<=PC+PC_STEP (wrapped). id_valid<=!flush. pc_wr_en=1, fe_latch_wr=1.
- Latency: imem_addr=A at edge N gives id_instr=mem[A], id_pc=A after edge N+1.
- Wrap: PC=2^ADDR_W-PC_STEP steps to 0 without a flag.
- pc_wr_en and fe_latch_wr are combinational from state/stall/redirect.
- Reset asserted mid-operation returns to BOOT immediately; any pending redirect is lost.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- Defined:
  - fetch_count increments on each edge where a valid instruction enters the latch (RUN, no redirect/stall/flush).
  - bubble_count increments on each edge where id_valid is cleared by redirect or flush.
  - Both counters wrap at 2^32 and reset to 0.
- Not defined: fetch_count and bubble_count are tied to 0 and no counter flops are generated.

Test Plan:
- Reset release, defaults, no stalls -> imem_en=0 for 1 cycle; imem_addr 16,17,18...; id_pc=16 with id_valid=1 one cycle after the first fetch edge.
- stall held 3 cycles at PC=20 -> imem_addr stays 20, id_* unchanged, pc_wr_en=0; fetch resumes at 21 afterwards.
- redirect=1, redirect_addr=0x0100, with stall=1 at PC=30 -> next imem_addr=0x0100, id_valid=0; next edge id_pc=0x0100, id_valid=1.
- ADDR_W=4, RESET_VEC=14, PC_STEP=1 -> imem_addr 14,15,0,1; id_next_pc for pc 15 = 0.
- flush=1 pulse for one cycle while running -> exactly one id_valid=0 cycle; PC advances normally.
- With FETCH_PERF_CNT_EN: 10 sequential fetches, 1 redirect, 1 flush -> fetch_count=10, bubble_count=2. Without the macro, both read 0.
